// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller.
// Opcode/funct values cover the 16 supported instructions.
package multi_cycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LW,
    CL_SW,
    CL_BR,
    CL_ILL
  } cls_t;

  typedef struct packed {
    cls_t cls;
    logic is_rtype;
    logic is_j;
    logic is_beq;
    logic is_bne;
    logic illegal;
  } dec_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [3:0] DM_ALL = 4'hF;

  function automatic logic fn_ok(input logic [5:0] fn);
    case (fn)
      FN_SLL, FN_SRL, FN_ADDU,
      FN_SUBU, FN_AND, FN_OR,
      FN_XOR, FN_NOR, FN_SLT:
        return 1'b1;
      default:
        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: IR/status in, enables out.
// master is the controller side, slave the datapath side.
interface multi_cycle_ctrl_if;

  logic [31:0] ir;
  logic        rs_eq_rt;
  logic        mem_ready;
  logic        step;

  logic        ir_wen;
  logic        pc_wen;
  logic        jbr_taken;
  logic        j_sel;
  logic        rf_wen;
  logic        rf_dst_rd;
  logic        wb_sel_mem;
  logic [3:0]  dm_wen;
  logic        dm_ren;
  logic [2:0]  state;
  logic        retired;
  logic        illegal;
  logic        mem_timeout;

  modport master (
    input  ir, rs_eq_rt, mem_ready, step,
    output ir_wen, pc_wen, jbr_taken, j_sel,
    output rf_wen, rf_dst_rd, wb_sel_mem,
    output dm_wen, dm_ren, state,
    output retired, illegal, mem_timeout
  );

  modport slave (
    output ir, rs_eq_rt, mem_ready, step,
    input  ir_wen, pc_wen, jbr_taken, j_sel,
    input  rf_wen, rf_dst_rd, wb_sel_mem,
    input  dm_wen, dm_ren, state,
    input  retired, illegal, mem_timeout
  );

endinterface

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational instruction classifier for the 16-op subset.
// Anything outside the subset decodes as CL_ILL.
module multi_cycle_ctrl_decode
  import multi_cycle_ctrl_pkg::*;
(
  input  logic [31:0] ir,
  output dec_t        dec
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       r_ok;
  logic       unused_ir;

  assign op        = ir[31:26];
  assign fn        = ir[5:0];
  assign r_ok      = (op == OP_RTYPE) && fn_ok(fn);
  assign unused_ir = ^ir[25:6];

  always_comb begin
    dec         = '0;
    dec.cls     = CL_ILL;
    dec.illegal = 1'b1;
    unique case (1'b1)
      r_ok: begin
        dec.cls      = CL_ALU;
        dec.is_rtype = 1'b1;
        dec.illegal  = 1'b0;
      end
      (op == OP_ADDIU),
      (op == OP_LUI): begin
        dec.cls     = CL_ALU;
        dec.illegal = 1'b0;
      end
      (op == OP_LW): begin
        dec.cls     = CL_LW;
        dec.illegal = 1'b0;
      end
      (op == OP_SW): begin
        dec.cls     = CL_SW;
        dec.illegal = 1'b0;
      end
      (op == OP_BEQ): begin
        dec.cls     = CL_BR;
        dec.is_beq  = 1'b1;
        dec.illegal = 1'b0;
      end
      (op == OP_BNE): begin
        dec.cls     = CL_BR;
        dec.is_bne  = 1'b1;
        dec.illegal = 1'b0;
      end
      (op == OP_J): begin
        dec.cls     = CL_BR;
        dec.is_j    = 1'b1;
        dec.illegal = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: IF/ID/EX/MEM/WB sequencing,
// data-RAM wait watchdog and single-step debug halt.
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter bit STEP_MODE = 1'b0,
  parameter int WD_LIMIT  = 16
)(
  input  logic               clk,
  input  logic               resetn,
  multi_cycle_ctrl_if.master bus
);

  localparam int CW =
    (WD_LIMIT > 2) ? $clog2(WD_LIMIT) : 1;
  localparam logic [CW-1:0] WD_LAST =
    CW'(WD_LIMIT - 1);
  localparam state_t NXT =
    STEP_MODE ? S_HALT : S_IF;

  dec_t          dec;
  state_t        cur;
  logic          step_q;
  logic [CW-1:0] wd_cnt;
  logic          wd_hit;
  logic          ill_q;
  logic          tmo_q;
  logic          rf_wen_q;
  logic          rf_dst_q;
  logic          wbm_q;
  logic [3:0]    dmw_q;
  logic          dmr_q;
  logic          jsel_q;

  logic in_if, in_id, in_ex, in_mem, in_wb;
  logic br_ex, fin;

  multi_cycle_ctrl_decode u_dec (
    .ir  (bus.ir),
    .dec (dec)
  );

  assign in_if  = (cur == S_IF);
  assign in_id  = (cur == S_ID);
  assign in_ex  = (cur == S_EX);
  assign in_mem = (cur == S_MEM);
  assign in_wb  = (cur == S_WB);
  assign br_ex  = in_ex && (dec.cls == CL_BR);

  assign wd_hit = (WD_LIMIT != 0)
               && (wd_cnt == WD_LAST);

  // final cycle of an instruction: pc update and retire coincide
  assign fin = (in_id && dec.illegal)
            || br_ex
            || (in_mem && (dec.cls == CL_SW)
                && bus.mem_ready)
            || in_wb;

  assign bus.pc_wen     = fin && resetn;
  assign bus.retired    = fin && resetn;
  assign bus.ir_wen     = in_if && resetn;
  assign bus.rf_wen     = rf_wen_q && resetn;
  assign bus.dm_wen     = dmw_q & {4{resetn}};
  assign bus.dm_ren     = dmr_q;
  assign bus.rf_dst_rd  = rf_dst_q;
  assign bus.wb_sel_mem = wbm_q;
  assign bus.j_sel      = jsel_q;
  assign bus.state      = cur;
  assign bus.illegal    = ill_q;
  assign bus.mem_timeout = tmo_q;

  assign bus.jbr_taken = br_ex && (dec.is_j
    || (dec.is_beq && bus.rs_eq_rt)
    || (dec.is_bne && !bus.rs_eq_rt));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cur      <= S_IF;
      step_q   <= 1'b0;
      wd_cnt   <= '0;
      ill_q    <= 1'b0;
      tmo_q    <= 1'b0;
      rf_wen_q <= 1'b0;
      rf_dst_q <= 1'b0;
      wbm_q    <= 1'b0;
      dmw_q    <= '0;
      dmr_q    <= 1'b0;
      jsel_q   <= 1'b0;
    end else begin
      step_q <= bus.step;
      unique case (cur)
        S_IF: cur <= S_ID;
        S_ID: begin
          if (dec.illegal) begin
            ill_q <= 1'b1;
            cur   <= NXT;
          end else begin
            jsel_q <= dec.is_j;
            cur    <= S_EX;
          end
        end
        S_EX: begin
          jsel_q <= 1'b0;
          unique case (dec.cls)
            CL_ALU: begin
              rf_wen_q <= 1'b1;
              rf_dst_q <= dec.is_rtype;
              cur      <= S_WB;
            end
            CL_LW: begin
              dmr_q <= 1'b1;
              cur   <= S_MEM;
            end
            CL_SW: begin
              dmw_q <= DM_ALL;
              cur   <= S_MEM;
            end
            default: cur <= NXT;
          endcase
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            wd_cnt <= '0;
            dmr_q  <= 1'b0;
            dmw_q  <= '0;
            if (dec.cls == CL_LW) begin
              rf_wen_q <= 1'b1;
              wbm_q    <= 1'b1;
              cur      <= S_WB;
            end else begin
              cur <= NXT;
            end
          end else if (wd_hit) begin
            // abort: the access never completes
            wd_cnt <= '0;
            dmr_q  <= 1'b0;
            dmw_q  <= '0;
            tmo_q  <= 1'b1;
            cur    <= S_ERR;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        S_WB: begin
          rf_wen_q <= 1'b0;
          rf_dst_q <= 1'b0;
          wbm_q    <= 1'b0;
          cur      <= NXT;
        end
        S_HALT: begin
          if (bus.step && !step_q)
            cur <= S_IF;
        end
        S_ERR: ;
        default: cur <= S_ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench for multi_cycle_ctrl: per-cycle expected
// output traces are queued per instruction and checked in order.
module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic       irw;
    logic       pcw;
    logic       jbr;
    logic       jsel;
    logic       rfw;
    logic       rd;
    logic       wbm;
    logic [3:0] dmw;
    logic       dmr;
    logic       ret;
  } obs_t;

  typedef struct {
    string tag;
    logic  rst;
    logic  mr;
    logic  eq;
    logic  stp;
    obs_t  e;
  } ent_t;

  localparam logic [31:0] I_ADDU  = 32'h00851021;
  localparam logic [31:0] I_ADDIU = 32'h24420005;
  localparam logic [31:0] I_LW    = 32'h8C820004;
  localparam logic [31:0] I_SW    = 32'hAC820000;
  localparam logic [31:0] I_BEQ   = 32'h10850003;
  localparam logic [31:0] I_BNE   = 32'h14850003;
  localparam logic [31:0] I_J     = 32'h08000010;
  localparam logic [31:0] I_ILL   = 32'hFC000000;

  logic clk;
  logic rn0;
  logic rn1;
  logic stp_lvl;
  int   total;
  int   bad;
  ent_t q[$];

  multi_cycle_ctrl_if b0 ();
  multi_cycle_ctrl_if b1 ();

  multi_cycle_ctrl #(
    .STEP_MODE (1'b0),
    .WD_LIMIT  (16)
  ) dut (
    .clk    (clk),
    .resetn (rn0),
    .bus    (b0)
  );

  multi_cycle_ctrl #(
    .STEP_MODE (1'b1),
    .WD_LIMIT  (16)
  ) dut_s (
    .clk    (clk),
    .resetn (rn1),
    .bus    (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "time limit");
  end

  function automatic obs_t z(input logic [2:0] st);
    obs_t r;
    r    = '0;
    r.st = st;
    return r;
  endfunction

  function automatic obs_t s0();
    obs_t r;
    r.st   = b0.state;
    r.irw  = b0.ir_wen;
    r.pcw  = b0.pc_wen;
    r.jbr  = b0.jbr_taken;
    r.jsel = b0.j_sel;
    r.rfw  = b0.rf_wen;
    r.rd   = b0.rf_dst_rd;
    r.wbm  = b0.wb_sel_mem;
    r.dmw  = b0.dm_wen;
    r.dmr  = b0.dm_ren;
    r.ret  = b0.retired;
    return r;
  endfunction

  function automatic obs_t s1();
    obs_t r;
    r.st   = b1.state;
    r.irw  = b1.ir_wen;
    r.pcw  = b1.pc_wen;
    r.jbr  = b1.jbr_taken;
    r.jsel = b1.j_sel;
    r.rfw  = b1.rf_wen;
    r.rd   = b1.rf_dst_rd;
    r.wbm  = b1.wb_sel_mem;
    r.dmw  = b1.dm_wen;
    r.dmr  = b1.dm_ren;
    r.ret  = b1.retired;
    return r;
  endfunction

  task automatic push(input string tag, input logic rst,
                      input logic mr, input logic eq,
                      input obs_t e);
    ent_t en;
    en.tag = tag;
    en.rst = rst;
    en.mr  = mr;
    en.eq  = eq;
    en.stp = stp_lvl;
    en.e   = e;
    q.push_back(en);
  endtask

  task automatic push_head(input string tag);
    obs_t e;
    e     = z(3'd0);
    e.irw = 1'b1;
    push(tag, 1'b1, 1'b0, 1'b0, e);
    push(tag, 1'b1, 1'b0, 1'b0, z(3'd1));
  endtask

  task automatic push_alu(input string tag, input logic rd);
    obs_t e;
    push_head(tag);
    push(tag, 1'b1, 1'b0, 1'b0, z(3'd2));
    e     = z(3'd4);
    e.rfw = 1'b1;
    e.rd  = rd;
    e.pcw = 1'b1;
    e.ret = 1'b1;
    push(tag, 1'b1, 1'b0, 1'b0, e);
  endtask

  task automatic push_lw(input string tag, input int waits);
    obs_t e;
    push_head(tag);
    push(tag, 1'b1, 1'b0, 1'b0, z(3'd2));
    e     = z(3'd3);
    e.dmr = 1'b1;
    for (int i = 0; i < waits; i++)
      push(tag, 1'b1, 1'b0, 1'b0, e);
    push(tag, 1'b1, 1'b1, 1'b0, e);
    e     = z(3'd4);
    e.rfw = 1'b1;
    e.wbm = 1'b1;
    e.pcw = 1'b1;
    e.ret = 1'b1;
    push(tag, 1'b1, 1'b0, 1'b0, e);
  endtask

  task automatic push_br(input string tag, input logic eq,
                         input logic tk, input logic js);
    obs_t e;
    push_head(tag);
    e      = z(3'd2);
    e.pcw  = 1'b1;
    e.jbr  = tk;
    e.jsel = js;
    e.ret  = 1'b1;
    push(tag, 1'b1, 1'b0, eq, e);
  endtask

  task automatic drain(input bit sel);
    ent_t en;
    obs_t o;
    while (q.size() > 0) begin
      en = q.pop_front();
      if (sel) begin
        rn1          = en.rst;
        b1.mem_ready = en.mr;
        b1.rs_eq_rt  = en.eq;
        b1.step      = en.stp;
      end else begin
        rn0          = en.rst;
        b0.mem_ready = en.mr;
        b0.rs_eq_rt  = en.eq;
        b0.step      = en.stp;
      end
      #1;
      o = sel ? s1() : s0();
      total++;
      assert (o === en.e) else begin
        bad++;
        $error("FAIL %s: got %h want %h",
               en.tag, o, en.e);
      end
      @(negedge clk);
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  initial begin
    obs_t e;
    total = 0;
    bad   = 0;
    rn0   = 1'b0;
    rn1   = 1'b0;
    stp_lvl = 1'b0;
    b0.ir = I_ADDU;
    b0.rs_eq_rt = 1'b0;
    b0.mem_ready = 1'b0;
    b0.step = 1'b0;
    b1.ir = I_ADDU;
    b1.rs_eq_rt = 1'b0;
    b1.mem_ready = 1'b0;
    b1.step = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_outs", 32'(s0()), 32'(z(3'd0)));
    chk("rst_ill", 32'(b0.illegal), 32'd0);
    chk("rst_tmo", 32'(b0.mem_timeout), 32'd0);

    b0.ir = I_ADDU;
    push_alu("addu", 1'b1);
    drain(1'b0);
    b0.ir = I_ADDIU;
    push_alu("addiu", 1'b0);
    drain(1'b0);

    b0.ir = I_LW;
    push_lw("lw_wait2", 2);
    drain(1'b0);
    push_lw("lw_fast", 0);
    drain(1'b0);

    b0.ir = I_BEQ;
    push_br("beq_eq", 1'b1, 1'b1, 1'b0);
    drain(1'b0);
    push_br("beq_ne", 1'b0, 1'b0, 1'b0);
    drain(1'b0);
    b0.ir = I_BNE;
    push_br("bne_ne", 1'b0, 1'b1, 1'b0);
    drain(1'b0);
    push_br("bne_eq", 1'b1, 1'b0, 1'b0);
    drain(1'b0);
    b0.ir = I_J;
    push_br("j", 1'b1, 1'b1, 1'b1);
    drain(1'b0);

    b0.ir = I_SW;
    push_head("sw_fast");
    push("sw_fast", 1'b1, 1'b0, 1'b0, z(3'd2));
    e     = z(3'd3);
    e.dmw = 4'hF;
    e.pcw = 1'b1;
    e.ret = 1'b1;
    push("sw_fast", 1'b1, 1'b1, 1'b0, e);
    drain(1'b0);

    push_head("sw_rst");
    push("sw_rst", 1'b1, 1'b0, 1'b0, z(3'd2));
    e     = z(3'd3);
    e.dmw = 4'hF;
    push("sw_rst", 1'b1, 1'b0, 1'b0, e);
    push("sw_rst", 1'b1, 1'b0, 1'b0, e);
    push("sw_rst_low", 1'b0, 1'b0, 1'b0, z(3'd3));
    drain(1'b0);
    #1;
    chk("sw_rst_state", 32'(b0.state), 32'd0);

    b0.ir = I_ILL;
    e     = z(3'd0);
    e.irw = 1'b1;
    push("ill", 1'b1, 1'b0, 1'b0, e);
    e     = z(3'd1);
    e.pcw = 1'b1;
    e.ret = 1'b1;
    push("ill", 1'b1, 1'b0, 1'b0, e);
    drain(1'b0);
    #1;
    chk("ill_flag", 32'(b0.illegal), 32'd1);
    chk("ill_state", 32'(b0.state), 32'd0);

    b0.ir = I_SW;
    push_head("sw_wd");
    push("sw_wd", 1'b1, 1'b0, 1'b0, z(3'd2));
    e     = z(3'd3);
    e.dmw = 4'hF;
    for (int i = 0; i < 16; i++)
      push("sw_wd_mem", 1'b1, 1'b0, 1'b0, e);
    push("sw_wd_err", 1'b1, 1'b0, 1'b0, z(3'd6));
    drain(1'b0);
    #1;
    chk("wd_tmo", 32'(b0.mem_timeout), 32'd1);
    chk("wd_state", 32'(b0.state), 32'd6);
    push("err_rst", 1'b0, 1'b0, 1'b0, z(3'd6));
    drain(1'b0);
    #1;
    chk("err_rst_state", 32'(b0.state), 32'd0);
    chk("err_rst_tmo", 32'(b0.mem_timeout), 32'd0);
    chk("err_rst_ill", 32'(b0.illegal), 32'd0);

    b1.ir   = I_ADDU;
    stp_lvl = 1'b0;
    push_alu("st_first", 1'b1);
    push("st_halt", 1'b1, 1'b0, 1'b0, z(3'd5));
    push("st_halt", 1'b1, 1'b0, 1'b0, z(3'd5));
    stp_lvl = 1'b1;
    push("st_edge", 1'b1, 1'b0, 1'b0, z(3'd5));
    push_alu("st_run", 1'b1);
    push("st_held", 1'b1, 1'b0, 1'b0, z(3'd5));
    stp_lvl = 1'b0;
    push("st_low", 1'b1, 1'b0, 1'b0, z(3'd5));
    drain(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
